// File: rtl/sobel_processor.sv
// Streaming 3x3 Sobel edge detector: RGB565 pixels in, |Gx|+|Gy| as grey RGB565 out.
// Per-column three-deep line history feeds a three-stage datapath with a fixed 3-clock latency.
module sobel_processor #(
    parameter int unsigned IMG_WIDTH   = 640,
    parameter int unsigned IMG_HEIGHT  = 480,
    parameter int unsigned PIXEL_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        href,
    input  logic        vsync,
    input  logic [15:0] pixel_in,
    input  logic        sobel_enable,
    output logic        pixel_valid,
    output logic [15:0] pixel_out
);

    localparam int unsigned PW = PIXEL_WIDTH;
    localparam int unsigned CW = $clog2(IMG_WIDTH + 1);
    localparam int unsigned AW = $clog2(IMG_WIDTH);
    localparam logic [CW-1:0] COL_END  = CW'(IMG_WIDTH);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);

    if (PIXEL_WIDTH != 8 || IMG_WIDTH < 3 || IMG_HEIGHT < 1) begin : g_param_check
        $error("sobel_processor: unsupported parameter set");
    end

    function automatic logic [10:0] z11(input logic [PW-1:0] v);
        return 11'(v);
    endfunction

    function automatic logic [9:0] abs11(input logic [10:0] v);
        return v[10] ? 10'(-v) : v[9:0];
    endfunction

    logic [CW-1:0] col;
    logic [1:0]    row;
    logic          href_d;

    logic          active_c;
    logic [AW-1:0] addr_c;
    logic [AW-1:0] addr_nxt_c;

    assign active_c   = href && (col < COL_END);
    assign addr_c     = AW'(col);
    assign addr_nxt_c = (col == COL_LAST) ? '0 : AW'(col + CW'(1));

    // Column and saturating row counters; the row advances on each href falling edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col    <= '0;
            row    <= '0;
            href_d <= 1'b0;
        end else begin
            href_d <= href;
            if (!href) begin
                col <= '0;
            end else if (col != COL_END) begin
                col <= col + CW'(1);
            end
            if (href_d && !href && row != 2'd3) begin
                row <= row + 2'd1;
            end
        end
    end

    logic [7:0]    r8_c, g8_c, b8_c;
    logic [15:0]   sum_c;
    logic [PW-1:0] gray_c;

    assign r8_c   = {pixel_in[15:11], pixel_in[15:13]};
    assign g8_c   = {pixel_in[10:5], pixel_in[10:9]};
    assign b8_c   = {pixel_in[4:0], pixel_in[4:2]};
    assign sum_c  = 16'd77 * {8'd0, r8_c} + 16'd151 * {8'd0, g8_c} + 16'd28 * {8'd0, b8_c};
    assign gray_c = PW'(sum_c[15:8]);

    logic [PW-1:0]        mem0 [IMG_WIDTH];
    logic [PW-1:0]        mem1 [IMG_WIDTH];
    logic [PW-1:0]        mem2 [IMG_WIDTH];
    logic [IMG_WIDTH-1:0] vld0, vld1, vld2;

    // Per-column history: mem0 newest row, mem2 oldest; the valid flags mask never-written cells.
    always_ff @(posedge clk) begin
        if (active_c) begin
            mem0[addr_c] <= gray_c;
            mem1[addr_c] <= mem0[addr_c];
            mem2[addr_c] <= mem1[addr_c];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld0 <= '0;
            vld1 <= '0;
            vld2 <= '0;
        end else if (active_c) begin
            vld0[addr_c] <= 1'b1;
            vld1[addr_c] <= vld0[addr_c];
            vld2[addr_c] <= vld1[addr_c];
        end
    end

    logic [PW-1:0] cur0_c, cur1_c, cur2_c, nxt0_c, nxt1_c, nxt2_c;

    assign cur0_c = vld0[addr_c]     ? mem0[addr_c]     : '0;
    assign cur1_c = vld1[addr_c]     ? mem1[addr_c]     : '0;
    assign cur2_c = vld2[addr_c]     ? mem2[addr_c]     : '0;
    assign nxt0_c = vld0[addr_nxt_c] ? mem0[addr_nxt_c] : '0;
    assign nxt1_c = vld1[addr_nxt_c] ? mem1[addr_nxt_c] : '0;
    assign nxt2_c = vld2[addr_nxt_c] ? mem2[addr_nxt_c] : '0;

    logic          s1_vld, s1_sobel;
    logic [15:0]   s1_pix;
    logic [PW-1:0] win [9];
    logic [PW-1:0] left_top, left_mid, left_bot;

    // Stage 1: assemble the window; the left column is the previous pixel's middle column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld   <= 1'b0;
            s1_sobel <= 1'b0;
            s1_pix   <= '0;
            win      <= '{default: '0};
            left_top <= '0;
            left_mid <= '0;
            left_bot <= '0;
        end else begin
            s1_vld   <= active_c && (!sobel_enable || (row >= 2'd2 && col != '0));
            s1_sobel <= sobel_enable;
            s1_pix   <= pixel_in;
            if (active_c) begin
                win[0]   <= left_top;
                win[3]   <= left_mid;
                win[6]   <= left_bot;
                win[1]   <= cur2_c;
                win[4]   <= cur1_c;
                win[7]   <= cur0_c;
                win[2]   <= nxt2_c;
                win[5]   <= nxt1_c;
                win[8]   <= nxt0_c;
                left_top <= cur1_c;
                left_mid <= cur0_c;
                left_bot <= gray_c;
            end
        end
    end

    logic [10:0] gx_c, gy_c;

    assign gx_c = z11(win[2]) + (z11(win[5]) << 1) + z11(win[8])
                - z11(win[0]) - (z11(win[3]) << 1) - z11(win[6]);
    assign gy_c = z11(win[6]) + (z11(win[7]) << 1) + z11(win[8])
                - z11(win[0]) - (z11(win[1]) << 1) - z11(win[2]);

    logic        s2_vld, s2_sobel;
    logic [15:0] s2_pix;
    logic [9:0]  s2_ax, s2_ay;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld   <= 1'b0;
            s2_sobel <= 1'b0;
            s2_pix   <= '0;
            s2_ax    <= '0;
            s2_ay    <= '0;
        end else begin
            s2_vld   <= s1_vld;
            s2_sobel <= s1_sobel;
            s2_pix   <= s1_pix;
            s2_ax    <= abs11(gx_c);
            s2_ay    <= abs11(gy_c);
        end
    end

    logic [11:0] mag_c;
    logic [7:0]  e_c;

    assign mag_c = 12'(s2_ax) + 12'(s2_ay);
    assign e_c   = (mag_c > 12'd255) ? 8'hFF : mag_c[7:0];

    logic        s3_vld;
    logic [15:0] s3_data;

    // Stage 3 packs the saturated magnitude as grey RGB565 or passes the raw pixel in bypass.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld      <= 1'b0;
            s3_data     <= '0;
            pixel_valid <= 1'b0;
            pixel_out   <= '0;
        end else begin
            s3_vld      <= s2_vld;
            s3_data     <= s2_sobel ? {e_c[7:3], e_c[7:2], e_c[7:3]} : s2_pix;
            pixel_valid <= s3_vld;
            pixel_out   <= s3_data;
        end
    end

    logic unused_c;
    assign unused_c = ^{vsync, sum_c[7:0]};

endmodule

// File: tb/tb_sobel_processor.sv
// Directed + randomized bench for sobel_processor against a row-based window model.
module tb_sobel_processor;

    localparam int W   = 16;
    localparam int H   = 8;
    localparam int GAP = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        href;
    logic        vsync;
    logic [15:0] pixel_in;
    logic        sobel_enable;
    logic        pixel_valid;
    logic [15:0] pixel_out;

    sobel_processor #(
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H),
        .PIXEL_WIDTH(8)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .href        (href),
        .vsync       (vsync),
        .pixel_in    (pixel_in),
        .sobel_enable(sobel_enable),
        .pixel_valid (pixel_valid),
        .pixel_out   (pixel_out)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int prev1 [W];
    int prev2 [W];
    int prev3 [W];
    int cur   [W];
    int mrow;
    int cur_row;

    logic        pv [3];
    logic [15:0] pd [3];
    int          pr [3];
    int          pc [3];

    int          obs_cnt;
    int          exp_cnt;
    logic [15:0] got [H][W];
    logic [15:0] line_pix [W];
    logic        line_en  [W];

    function automatic int gray_of(input logic [15:0] p);
        int r5, g6, b5, r8, g8, b8;
        r5 = int'(p[15:11]);
        g6 = int'(p[10:5]);
        b5 = int'(p[4:0]);
        r8 = r5 * 8 + r5 / 4;
        g8 = g6 * 4 + g6 / 16;
        b8 = b5 * 8 + b5 / 4;
        return (77 * r8 + 151 * g8 + 28 * b8) / 256;
    endfunction

    // Window taken straight from the row arrays: prev1 = row r-1, prev2 = r-2, prev3 = r-3.
    function automatic logic [15:0] sobel_at(input int c);
        int p0, p1, p2, p3, p4, p5, p6, p7, p8, gx, gy, mag, e;
        p0 = prev2[c-1]; p3 = prev1[c-1]; p6 = cur[c-1];
        p1 = prev3[c];   p4 = prev2[c];   p7 = prev1[c];
        if (c < W - 1) begin
            p2 = prev3[c+1]; p5 = prev2[c+1]; p8 = prev1[c+1];
        end else begin
            p2 = prev2[0];   p5 = prev1[0];   p8 = cur[0];
        end
        gx  = -p0 + p2 - 2 * p3 + 2 * p5 - p6 + p8;
        gy  = -p0 - 2 * p1 - p2 + p6 + 2 * p7 + p8;
        mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        e   = (mag > 255) ? 255 : mag;
        return 16'(((e / 8) << 11) | ((e / 4) << 5) | (e / 8));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < W; i++) begin
            prev1[i] = 0; prev2[i] = 0; prev3[i] = 0; cur[i] = 0;
        end
        mrow = 0;
        for (int i = 0; i < 3; i++) begin
            pv[i] = 1'b0; pd[i] = 16'h0; pr[i] = 0; pc[i] = 0;
        end
    endtask

    task automatic clear_got();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) got[r][c] = 16'hDEAD;
    endtask

    // One clock: drive inputs, predict this sample, then check the sample from three clocks ago.
    task automatic step(input logic h, input logic [15:0] p, input logic en, input int c);
        logic        ev;
        logic [15:0] ed;
        ev = 1'b0;
        ed = 16'h0;
        href = h;
        pixel_in = p;
        sobel_enable = en;
        if (h && rst_n) begin
            cur[c] = gray_of(p);
            if (!en) begin
                ev = 1'b1; ed = p;
            end else if (mrow >= 2 && c >= 1) begin
                ev = 1'b1; ed = sobel_at(c);
            end
        end
        @(posedge clk);
        #1;
        check("valid", 32'(pixel_valid), 32'(pv[2]));
        if (pv[2]) begin
            check($sformatf("data r%0d c%0d", pr[2], pc[2]), 32'(pixel_out), 32'(pd[2]));
            got[pr[2]][pc[2]] = pixel_out;
        end
        if (pixel_valid) obs_cnt++;
        if (ev) exp_cnt++;
        pv[2] = pv[1]; pd[2] = pd[1]; pr[2] = pr[1]; pc[2] = pc[1];
        pv[1] = pv[0]; pd[1] = pd[0]; pr[1] = pr[0]; pc[1] = pc[0];
        pv[0] = ev;    pd[0] = ed;    pr[0] = cur_row; pc[0] = c;
    endtask

    task automatic run_line();
        for (int c = 0; c < W; c++) step(1'b1, line_pix[c], line_en[c], c);
        prev3 = prev2;
        prev2 = prev1;
        prev1 = cur;
        if (mrow < 3) mrow++;
        for (int i = 0; i < GAP; i++) step(1'b0, 16'h0, 1'b1, 0);
    endtask

    // kind: 0 white/edge, 1 random/edge, 2 random/random enable, 3 random/bypass
    task automatic fill_line(input int kind);
        for (int c = 0; c < W; c++) begin
            line_pix[c] = (kind == 0) ? 16'hFFFF : 16'($urandom);
            line_en[c]  = (kind == 3) ? 1'b0 : (kind == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    task automatic run_frame(input int kind);
        obs_cnt = 0;
        exp_cnt = 0;
        clear_got();
        for (int r = 0; r < H; r++) begin
            cur_row = r;
            fill_line(kind);
            run_line();
        end
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        href  = 1'b0;
        model_reset();
        #1;
        check("valid at reset", 32'(pixel_valid), 32'd0);
        check("out at reset", 32'(pixel_out), 32'd0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 16'h0, 1'b1, 0);
            check("out in reset", 32'(pixel_out), 32'd0);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; href = 1'b0; vsync = 1'b0; pixel_in = 16'h0; sobel_enable = 1'b1;
        obs_cnt = 0; exp_cnt = 0; cur_row = 0;
        model_reset();
        clear_got();
        repeat (3) @(posedge clk);
        #1;
        check("reset valid", 32'(pixel_valid), 32'd0);
        check("reset out", 32'(pixel_out), 32'd0);
        rst_n = 1'b1;
        vsync = 1'b1;
        for (int i = 0; i < 2; i++) step(1'b0, 16'h0, 1'b1, 0);
        vsync = 1'b0;
        step(1'b0, 16'h0, 1'b1, 0);

        // First frame after reset, all white
        run_frame(0);
        check("frame1 count", 32'(obs_cnt), 32'((H - 2) * (W - 1)));
        check("white r2c1", 32'(got[2][1]), 32'h0000_FFFF);
        check("white r3c5", 32'(got[3][5]), 32'h0);
        check("white last", 32'(got[H-1][W-1]), 32'h0);

        // Second frame reuses the previous frame's rows
        run_frame(0);
        check("frame2 count", 32'(obs_cnt), 32'(H * (W - 1)));
        check("frame2 r0c1", 32'(got[0][1]), 32'h0);

        // Directed small-gray / saturation pattern from cleared buffers
        pulse_reset();
        for (int i = 0; i < 2; i++) step(1'b0, 16'h0, 1'b1, 0);
        obs_cnt = 0;
        clear_got();
        for (int r = 0; r < 4; r++) begin
            cur_row = r;
            for (int c = 0; c < W; c++) begin
                line_en[c] = 1'b1;
                if (r == 2)      line_pix[c] = (c == 0) ? 16'h0200 : 16'hF800;
                else if (r == 3) line_pix[c] = (c == 0) ? 16'hF800 : 16'h0000;
                else             line_pix[c] = 16'h0000;
            end
            run_line();
        end
        check("mag76 r2c1", 32'(got[2][1]), 32'h4A69);
        check("wrap r2 last", 32'(got[2][W-1]), 32'h9CD3);
        check("sat r3c1", 32'(got[3][1]), 32'hFFFF);
        check("pattern count", 32'(obs_cnt), 32'(2 * (W - 1)));

        // Randomized frames
        run_frame(1);
        check("rand count", 32'(obs_cnt), 32'(H * (W - 1)));
        run_frame(2);
        check("mixed count", 32'(obs_cnt), 32'(exp_cnt));
        run_frame(3);
        check("bypass count", 32'(obs_cnt), 32'(H * W));

        // Reset in the middle of a frame and line
        for (int r = 0; r < H / 3; r++) begin
            cur_row = r;
            fill_line(1);
            run_line();
        end
        cur_row = H / 3;
        fill_line(1);
        for (int c = 0; c < W / 4; c++) step(1'b1, line_pix[c], 1'b1, c);
        pulse_reset();
        for (int i = 0; i < 3; i++) step(1'b0, 16'h0, 1'b1, 0);
        run_frame(1);
        check("post-reset frame1 count", 32'(obs_cnt), 32'((H - 2) * (W - 1)));
        run_frame(1);
        check("post-reset frame2 count", 32'(obs_cnt), 32'(H * (W - 1)));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sobel_processor.md
Name: sobel_processor

Overview:
- Streaming Sobel edge detector between the camera capture interface (RGB565, href/vsync framing) and the display/frame-buffer path.
- Each pixel is converted to 8-bit grayscale and stored in line buffers. The block then computes |Gx|+|Gy| over a 3x3 window, saturates the result to 8 bits, and emits it as grey RGB565 with a valid strobe.

Parameters:
- IMG_WIDTH, 640, active pixels per line (column index 0..IMG_WIDTH-1).
- IMG_HEIGHT, 480, lines per frame (informational; no internal frame-length check).
- PIXEL_WIDTH, 8, grayscale sample width.

Ports:
- clk  in  1  pixel clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- href  in  1  line-active qualifier; one pixel per clk while high.
- vsync  in  1  frame sync; accepted but has no effect on datapath state.
- pixel_in  in  16  RGB565 pixel, sampled when href=1.
- sobel_enable  in  1  1 = edge output; 0 = bypass.
- pixel_valid  out  1  pixel_out is valid this cycle.
- pixel_out  out  16  RGB565 result.

Behaviour:
- Reset (async, rst_n=0):
  - pixel_valid=0, pixel_out=0, col=0, row count=0, pipeline flushed.
  - All line-buffer contents read as 0 afterwards (clear, or per-row-slot valid flags masking reads to 0).
  - Reset mid-line or mid-frame discards all in-flight results.
- Column counter col: +1 per href=1 cycle; cleared when href=0. Pixels with col>=IMG_WIDTH are ignored (no write, no output).
- Row counter R: +1 on each href falling edge; saturates at 3.
  - R is NOT cleared by vsync.
  - Line buffers persist across frames, so frame N's first rows use frame N-1's last rows.
- Grayscale, 8-bit, for each pixel:
  - Expand channels: r8={r5,r5[4:2]}, g8={g6,g6[5:4]}, b8={b5,b5[4:2]}.
  - sum=77*r8+151*g8+28*b8 (16-bit); gray=sum[15:8]. Example: 0xFFFF -> 255.
- Window: the incoming pixel at row r (=R), column c uses gray G(row,col); rows never written since reset read as 0.
  - p0=G(r-2,c-1), p3=G(r-1,c-1), p6=G(r,c-1)
  - p1=G(r-3,c), p4=G(r-2,c), p7=G(r-1,c)
  - If c<IMG_WIDTH-1: p2=G(r-3,c+1), p5=G(r-2,c+1), p8=G(r-1,c+1)
  - If c=IMG_WIDTH-1 (wrap): p2=G(r-2,0), p5=G(r-1,0), p8=G(r,0)
  - This equals three per-column history registers mem0/mem1/mem2, read before the current pixel shifts mem2<=mem1<=mem0<=gray at column c.
- Arithmetic, 11-bit signed:
  - Gx=-p0+p2-2p3+2p5-p6+p8
  - Gy=-p0-2p1-p2+p6+2p7+p8
  - mag=|Gx|+|Gy| (12-bit); e=mag>255 ? 255 : mag[7:0].
  - pixel_out={e[7:3],e[7:2],e[7:3]}.
- Output rule: a result is produced only when R>=2 and c>=1, i.e. IMG_WIDTH-1 results per qualifying line.
- Latency: exactly 3 clocks; input sampled at edge k -> pixel_valid=1 with data after edge k+3. Results are strictly in input order.
- pixel_valid may be high only while href=1 or within 3 cycles after href falls; otherwise 0.
- sobel_enable=0 (bypass): every href pixel (col<IMG_WIDTH) appears unchanged on pixel_out with the same 3-cycle latency and pixel_valid. Line buffers still update.
- Switching sobel_enable mid-line takes effect for pixels sampled after the change.

Test Plan:
- First frame after reset, all pixels 0xFFFF, enable=1:
  - Row 2 outputs: c=1 gives Gx=-255, Gy=765 -> 0xFFFF.
  - Rows>=3: every output 0x0000.
  - Total valid count = (IMG_HEIGHT-2)*(IMG_WIDTH-1).
- Second frame (no reset) -> valid count = IMG_HEIGHT*(IMG_WIDTH-1); row 0 windows use the previous frame's rows.
- Rows of 0x0000 then one row of 0xF800 (gray 76): first window with p6=p7=p8=76, all others 0 -> Gy=304 -> saturated 0xFFFF. Check a case with mag=76 -> 0x4A69.
- Random RGB565 frames with random seed, compared against a bit-exact model of the window/gray/pack rules -> zero mismatches, exact counts.
- rst_n pulsed low 5 clocks at row IMG_HEIGHT/3, col IMG_WIDTH/4 -> no valid during or after reset until row 2 of the next stream; next two frames match a model started from zeroed buffers.
- Handshake: valid never asserted more than 3 cycles after href falls; latency exactly 3 cycles; sobel_enable=0 -> pixel_out equals pixel_in delayed 3 clocks, IMG_WIDTH valids per line.
